// File: rtl/lighting_scheduler.sv
// Room lighting controller: luminosity hysteresis, occupancy hold timer and
// stepped brightness ramps driving a 0..7 lamp level.
module lighting_scheduler #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned DARK_ON     = 3,
  parameter int unsigned DARK_OFF    = 5,
  parameter int unsigned RAMP_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] luminosity,
  input  logic       motionSensor,
  input  logic       override_en,
  input  logic       override_on,
  output logic [2:0] level,
  output logic       light,
  output logic [2:0] state
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [2:0]    DARK_ON_L  = 3'(DARK_ON);
  localparam logic [2:0]    DARK_OFF_L = 3'(DARK_OFF);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ON        = 3'd2,
    S_HOLD      = 3'd3,
    S_RAMP_DOWN = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [2:0]    level_r, level_s;
  logic          dark_r, dark_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic [RW-1:0] ramp_cnt_r, ramp_cnt_s;
  logic          step_up_s, step_down_s;

  // Dark flag with hysteresis band between DARK_ON and DARK_OFF
  always_comb begin
    dark_s = dark_r;
    if (luminosity <= DARK_ON_L) begin
      dark_s = 1'b1;
    end else if (luminosity >= DARK_OFF_L) begin
      dark_s = 1'b0;
    end else begin
      dark_s = dark_r;
    end
  end

  // Next-state, level, hold timer and ramp divider
  always_comb begin
    state_s     = state_r;
    level_s     = level_r;
    hold_cnt_s  = hold_cnt_r;
    ramp_cnt_s  = '0;
    step_up_s   = 1'b0;
    step_down_s = 1'b0;

    case (state_r)
      S_OFF: begin
        if (override_en) begin
          state_s = override_on ? S_RAMP_UP : S_OFF;
        end else if (dark_r && motionSensor) begin
          state_s = S_RAMP_UP;
        end else begin
          state_s = S_OFF;
        end
      end
      S_RAMP_UP: begin
        if (override_en && !override_on) begin
          state_s = S_RAMP_DOWN;
        end else if (!override_en && !dark_r) begin
          state_s = S_RAMP_DOWN;
        end else begin
          step_up_s = 1'b1;
        end
      end
      S_ON: begin
        if (override_en) begin
          state_s = override_on ? S_ON : S_RAMP_DOWN;
        end else if (!dark_r) begin
          state_s = S_RAMP_DOWN;
        end else if (motionSensor) begin
          state_s = S_ON;
        end else begin
          state_s = S_HOLD;
        end
      end
      S_HOLD: begin
        if (override_en) begin
          state_s = override_on ? S_RAMP_UP : S_RAMP_DOWN;
        end else if (!dark_r) begin
          state_s = S_RAMP_DOWN;
        end else if (motionSensor) begin
          state_s    = S_ON;
          hold_cnt_s = HOLD_LOAD;
        end else if (hold_cnt_r == '0) begin
          state_s = S_RAMP_DOWN;
        end else begin
          hold_cnt_s = hold_cnt_r - HW'(1);
        end
      end
      S_RAMP_DOWN: begin
        if (override_en) begin
          if (override_on) begin
            state_s = S_RAMP_UP;
          end else begin
            step_down_s = 1'b1;
          end
        end else if (dark_r && motionSensor) begin
          state_s = S_RAMP_UP;
        end else begin
          step_down_s = 1'b1;
        end
      end
      default: begin
        state_s = S_OFF;
        level_s = 3'd0;
      end
    endcase

    // One saturating step per RAMP_DIV cycles; ramp_cnt_s stays 0 on any entry
    if (step_up_s || step_down_s) begin
      if (ramp_cnt_r == RAMP_LAST) begin
        ramp_cnt_s = '0;
        if (step_up_s) begin
          level_s = (level_r == 3'd7) ? 3'd7 : level_r + 3'd1;
          state_s = (level_s == 3'd7) ? S_ON : S_RAMP_UP;
        end else begin
          level_s = (level_r == 3'd0) ? 3'd0 : level_r - 3'd1;
          state_s = (level_s == 3'd0) ? S_OFF : S_RAMP_DOWN;
        end
      end else begin
        ramp_cnt_s = ramp_cnt_r + RW'(1);
      end
    end else begin
      ramp_cnt_s = '0;
    end

    if (override_en || (state_r == S_ON)) begin
      hold_cnt_s = HOLD_LOAD;
    end else begin
      hold_cnt_s = hold_cnt_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_OFF;
      level_r    <= 3'd0;
      dark_r     <= 1'b0;
      hold_cnt_r <= '0;
      ramp_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      level_r    <= level_s;
      dark_r     <= dark_s;
      hold_cnt_r <= hold_cnt_s;
      ramp_cnt_r <= ramp_cnt_s;
    end
  end

  assign level = level_r;
  assign light = |level_r;
  assign state = state_r;

endmodule

// File: tb/tb_lighting_scheduler.sv
// Randomized and directed bench for lighting_scheduler, checked cycle by
// cycle against a rule-level reference model.
module tb_lighting_scheduler;

  localparam int HOLD = 16;
  localparam int DON  = 3;
  localparam int DOFF = 5;
  localparam int DIV  = 2;
  localparam int OFF = 0, UP = 1, ON = 2, HLD = 3, DN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] luminosity = 3'd7;
  logic       motionSensor = 1'b0;
  logic       override_en = 1'b0;
  logic       override_on = 1'b0;
  logic [2:0] level;
  logic       light;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int m_state, m_level, m_dark, m_hold, m_ramp;

  lighting_scheduler #(.HOLD_CYCLES(HOLD), .DARK_ON(DON), .DARK_OFF(DOFF), .RAMP_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .luminosity(luminosity), .motionSensor(motionSensor),
    .override_en(override_en), .override_on(override_on),
    .level(level), .light(light), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = OFF; m_level = 0; m_dark = 0; m_hold = 0; m_ramp = 0;
  endtask

  // One clock of the behavioural rules, applied to the inputs seen at the edge
  task automatic model_step(input int lum, input int mot, input int oen, input int oon);
    int ns, nl, nh, nr;
    ns = m_state; nl = m_level; nh = m_hold; nr = 0;
    if (oen != 0) begin
      nh = HOLD - 1;
      if (oon != 0) ns = (m_state == ON) ? ON : UP;
      else          ns = (m_state == OFF) ? OFF : DN;
    end else if (m_dark == 0) begin
      ns = (m_state == OFF) ? OFF : DN;
    end else if (mot != 0) begin
      if (m_state == ON || m_state == HLD) begin ns = ON; nh = HOLD - 1; end
      else ns = UP;
    end else begin
      if (m_state == ON) begin ns = HLD; nh = HOLD - 1; end
      else if (m_state == HLD) begin
        if (m_hold == 0) ns = DN;
        else nh = m_hold - 1;
      end
    end
    if (ns == m_state && (ns == UP || ns == DN)) begin
      if (m_ramp == DIV - 1) begin
        nr = 0;
        if (ns == UP) begin
          nl = (m_level + 1 > 7) ? 7 : m_level + 1;
          if (nl == 7) ns = ON;
        end else begin
          nl = (m_level - 1 < 0) ? 0 : m_level - 1;
          if (nl == 0) ns = OFF;
        end
      end else begin
        nr = m_ramp + 1;
      end
    end
    if (lum <= DON) m_dark = 1;
    else if (lum >= DOFF) m_dark = 0;
    m_state = ns; m_level = nl; m_hold = nh; m_ramp = nr;
  endtask

  task automatic drive(input int lum, input int mot, input int oen, input int oon);
    luminosity = 3'(lum); motionSensor = (mot != 0);
    override_en = (oen != 0); override_on = (oon != 0);
    @(posedge clk);
    model_step(lum, mot, oen, oon);
    #1;
    check_value("state", int'(state), m_state);
    check_value("level", int'(level), m_level);
    check_value("light", int'(light), (m_level != 0) ? 1 : 0);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_value("rst_state", int'(state), OFF);
    check_value("rst_level", int'(level), 0);
    check_value("rst_light", int'(light), 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int mode, len, ov, oon, mprob, lum;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_value("por_state", int'(state), OFF);
    check_value("por_level", int'(level), 0);
    rst = 1'b0;

    // Turn on in the dark, then reset mid-ramp at level 4
    repeat (10) drive(2, 1, 0, 0);
    check_value("ramp_lvl4", int'(level), 4);
    pulse_reset();
    repeat (3) drive(2, 0, 0, 0);

    // Full ramp up, hold timing and ramp down
    pulse_reset();
    repeat (16) drive(2, 1, 0, 0);
    check_value("on_state", int'(state), ON);
    check_value("on_level", int'(level), 7);
    for (int i = 0; i < 16; i++) begin
      drive(2, 0, 0, 0);
      check_value("hold_state", int'(state), HLD);
    end
    drive(2, 0, 0, 0);
    check_value("hold_expire", int'(state), DN);
    repeat (14) drive(2, 0, 0, 0);
    check_value("down_off", int'(state), OFF);
    check_value("down_light", int'(light), 0);

    // Hysteresis band keeps the light on; crossing DARK_OFF ramps it down
    repeat (18) drive(2, 1, 0, 0);
    repeat (5) drive(4, 1, 0, 0);
    check_value("hyst_on", int'(state), ON);
    repeat (2) drive(5, 1, 0, 0);
    check_value("hyst_down", int'(state), DN);
    repeat (5) drive(4, 1, 0, 0);
    check_value("hyst_stay_dn", int'(state), DN);
    repeat (12) drive(4, 1, 0, 0);

    // Override while bright, then release into HOLD in the dark
    repeat (20) drive(7, 0, 1, 1);
    check_value("ovr_on", int'(level), 7);
    repeat (16) drive(7, 0, 1, 0);
    check_value("ovr_off", int'(state), OFF);
    repeat (20) drive(2, 0, 1, 1);
    for (int i = 0; i < 16; i++) begin
      drive(2, 0, 0, 0);
      check_value("rel_hold", int'(state), HLD);
    end

    // Random segments
    for (int seg = 0; seg < 60; seg++) begin
      mode  = $urandom_range(0, 2);
      len   = $urandom_range(10, 80);
      ov    = ($urandom_range(0, 7) == 0) ? 1 : 0;
      oon   = $urandom_range(0, 1);
      mprob = $urandom_range(0, 100);
      for (int c = 0; c < len; c++) begin
        if (mode == 0) lum = $urandom_range(0, 3);
        else if (mode == 1) lum = $urandom_range(2, 5);
        else lum = $urandom_range(4, 7);
        drive(lum, ($urandom_range(0, 99) < mprob) ? 1 : 0, ov, oon);
        if ($urandom_range(0, 399) == 0) pulse_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
